mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 148 ++++++++++++++
 tb/tb_mem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Byte-wide memory responder with programmable wait states, one-cycle ready pulse
// and a side loader port for preloading program bytes.
module mem_responder #(
   parameter int WIDTH   = 8,
   parameter int WAITCYC = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic             memwrite,
   input  logic [WIDTH-1:0] adr,
   input  logic [WIDTH-1:0] writedata,
   output logic [WIDTH-1:0] memdata,
   output logic             ready,
   output logic             busy,
   input  logic             ld_en,
   input  logic [WIDTH-1:0] ld_adr,
   input  logic [WIDTH-1:0] ld_data,
   output logic             ld_ack
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESPOND = 2'd2
   } state_t;

   localparam int       DEPTH    = 1 << WIDTH;
   localparam logic [3:0] CNT_INIT = (WAITCYC == 0) ? 4'd0 : 4'(WAITCYC - 1);

   state_t           state_r;
   state_t           state_s;
   logic [3:0]       cnt_r;
   logic [WIDTH-1:0] adr_r;
   logic [WIDTH-1:0] wd_r;
   logic             we_r;
   logic             accept_s;
   logic             load_s;
   logic [WIDTH-1:0] rd_adr_s;
   logic             rd_we_s;
   logic             mem_we_s;
   logic [WIDTH-1:0] mem_wadr_s;
   logic [WIDTH-1:0] mem_wdata_s;
   logic [WIDTH-1:0] mem_r [0:DEPTH-1];

   // Loader has priority over a simultaneous request; the request stays pending.
   assign load_s   = (state_r == IDLE) && ld_en;
   assign accept_s = (state_r == IDLE) && req && !ld_en;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = (WAITCYC == 0) ? RESPOND : WAIT;
            end else begin
               state_s = IDLE;
            end
         end
         WAIT: begin
            if (cnt_r == 4'd0) begin
               state_s = RESPOND;
            end else begin
               state_s = WAIT;
            end
         end
         RESPOND: state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Output/port decode: read address source and the single memory write port.
   always_comb begin
      rd_adr_s    = adr_r;
      rd_we_s     = we_r;
      mem_we_s    = 1'b0;
      mem_wadr_s  = adr_r;
      mem_wdata_s = wd_r;
      case (state_r)
         IDLE: begin
            // With zero wait states the read is issued from the live inputs.
            rd_adr_s = adr;
            rd_we_s  = memwrite;
            if (ld_en) begin
               mem_we_s    = 1'b1;
               mem_wadr_s  = ld_adr;
               mem_wdata_s = ld_data;
            end else begin
               mem_we_s    = 1'b0;
            end
         end
         WAIT:    mem_we_s = 1'b0;
         RESPOND: mem_we_s = we_r;
         default: mem_we_s = 1'b0;
      endcase
   end

   // Request latch, wait counter and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r   <= 4'd0;
         adr_r   <= '0;
         wd_r    <= '0;
         we_r    <= 1'b0;
         memdata <= '0;
         ready   <= 1'b0;
         busy    <= 1'b0;
         ld_ack  <= 1'b0;
      end else begin
         ready  <= (state_s == RESPOND);
         busy   <= (state_s != IDLE);
         ld_ack <= load_s;
         if (accept_s) begin
            adr_r <= adr;
            wd_r  <= writedata;
            we_r  <= memwrite;
            cnt_r <= CNT_INIT;
         end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
         end else begin
            cnt_r <= cnt_r;
         end
         if ((state_s == RESPOND) && !rd_we_s) begin
            memdata <= mem_r[rd_adr_s];
         end else begin
            memdata <= memdata;
         end
      end
   end

   // Storage array; deliberately not reset so contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[mem_wadr_s] <= mem_wdata_s;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: WAITCYC=2 and WAITCYC=0 instances,
// directed table, corner sequences and randomized traffic against an array model.
module tb_mem_responder;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_a     [2];
   logic       we_a      [2];
   logic       ld_en_a   [2];
   logic [7:0] adr_a     [2];
   logic [7:0] wd_a      [2];
   logic [7:0] ld_adr_a  [2];
   logic [7:0] ld_data_a [2];
   logic [7:0] md_a      [2];
   logic       ready_a   [2];
   logic       busy_a    [2];
   logic       ack_a     [2];

   int checks = 0;
   int errors = 0;

   logic [7:0] ref_mem   [2][256];
   bit         ref_valid [2][256];
   logic [7:0] ref_md    [2];

   typedef struct {
      bit         ld;
      bit         w;
      logic [7:0] a;
      logic [7:0] d;
      logic [7:0] exp;
   } vec_t;
   vec_t tbl [10];

   always #5 clk = ~clk;

   mem_responder #(.WIDTH(8), .WAITCYC(2)) dut0 (
      .clk(clk), .reset(reset), .req(req_a[0]), .memwrite(we_a[0]),
      .adr(adr_a[0]), .writedata(wd_a[0]), .memdata(md_a[0]),
      .ready(ready_a[0]), .busy(busy_a[0]), .ld_en(ld_en_a[0]),
      .ld_adr(ld_adr_a[0]), .ld_data(ld_data_a[0]), .ld_ack(ack_a[0])
   );

   mem_responder #(.WIDTH(8), .WAITCYC(0)) dut1 (
      .clk(clk), .reset(reset), .req(req_a[1]), .memwrite(we_a[1]),
      .adr(adr_a[1]), .writedata(wd_a[1]), .memdata(md_a[1]),
      .ready(ready_a[1]), .busy(busy_a[1]), .ld_en(ld_en_a[1]),
      .ld_adr(ld_adr_a[1]), .ld_data(ld_data_a[1]), .ld_ack(ack_a[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int s, input logic [7:0] a, input logic [7:0] d);
      ld_en_a[s]   = 1'b1;
      ld_adr_a[s]  = a;
      ld_data_a[s] = d;
      tick();
      ld_en_a[s] = 1'b0;
      check("ld_ack", 32'(ack_a[s]), 32'd1);
      ref_mem[s][a]   = d;
      ref_valid[s][a] = 1'b1;
      tick();
      check("ld_ack_pulse", 32'(ack_a[s]), 32'd0);
      check("ld_memdata_hold", 32'(md_a[s]), 32'(ref_md[s]));
   endtask

   task automatic do_access(input int s, input bit w, input logic [7:0] a,
                            input logic [7:0] d, output logic [7:0] md_seen);
      int lat  = 0;
      int bcnt = 0;
      bit got  = 1'b0;
      int wc   = (s == 0) ? 2 : 0;
      md_seen   = 8'h00;
      req_a[s]  = 1'b1;
      we_a[s]   = w;
      adr_a[s]  = a;
      wd_a[s]   = d;
      for (int i = 0; i < 40 && !got; i++) begin
         tick();
         lat++;
         if (busy_a[s]) bcnt++;
         if (ready_a[s]) begin
            got = 1'b1;
         end else begin
            // Scramble request inputs after acceptance; latched copies must be used.
            adr_a[s] = 8'($urandom);
            wd_a[s]  = 8'($urandom);
            we_a[s]  = 1'($urandom);
         end
      end
      req_a[s] = 1'b0;
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: inst %0d no ready within 40 cycles", s);
      end else begin
         check("latency", 32'(lat), 32'(wc + 1));
         check("busy_cycles", 32'(bcnt), 32'(wc + 1));
         if (!w) ref_md[s] = ref_mem[s][a];
         check("memdata", 32'(md_a[s]), 32'(ref_md[s]));
         md_seen = md_a[s];
         if (w) begin
            ref_mem[s][a]   = d;
            ref_valid[s][a] = 1'b1;
         end
         tick();
         check("ready_pulse", 32'(ready_a[s]), 32'd0);
         check("busy_idle", 32'(busy_a[s]), 32'd0);
      end
   endtask

   initial begin
      logic [7:0] md;
      int n;
      int rcnt;
      bit got;

      for (int s = 0; s < 2; s++) begin
         req_a[s] = 1'b0; we_a[s] = 1'b0; ld_en_a[s] = 1'b0;
         adr_a[s] = 8'h00; wd_a[s] = 8'h00; ld_adr_a[s] = 8'h00; ld_data_a[s] = 8'h00;
         ref_md[s] = 8'h00;
         for (int i = 0; i < 256; i++) ref_valid[s][i] = 1'b0;
      end

      // Reset held for three cycles.
      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      for (int s = 0; s < 2; s++) begin
         check("rst_memdata", 32'(md_a[s]), 32'd0);
         check("rst_ready", 32'(ready_a[s]), 32'd0);
         check("rst_busy", 32'(busy_a[s]), 32'd0);
         check("rst_ld_ack", 32'(ack_a[s]), 32'd0);
      end

      // Directed table: preload + fetch, then store and load back.
      tbl[0] = '{1'b1, 1'b0, 8'h00, 8'h20, 8'h00};
      tbl[1] = '{1'b1, 1'b0, 8'h01, 8'h02, 8'h00};
      tbl[2] = '{1'b1, 1'b0, 8'h02, 8'h00, 8'h00};
      tbl[3] = '{1'b1, 1'b0, 8'h03, 8'h05, 8'h00};
      tbl[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h20};
      tbl[5] = '{1'b0, 1'b0, 8'h01, 8'h00, 8'h02};
      tbl[6] = '{1'b0, 1'b0, 8'h02, 8'h00, 8'h00};
      tbl[7] = '{1'b0, 1'b0, 8'h03, 8'h00, 8'h05};
      tbl[8] = '{1'b0, 1'b1, 8'h40, 8'hA5, 8'h05};
      tbl[9] = '{1'b0, 1'b0, 8'h40, 8'h00, 8'hA5};
      for (int i = 0; i < 10; i++) begin
         if (tbl[i].ld) begin
            do_load(0, tbl[i].a, tbl[i].d);
         end else begin
            do_access(0, tbl[i].w, tbl[i].a, tbl[i].d, md);
            check($sformatf("tbl%0d_memdata", i), 32'(md), 32'(tbl[i].exp));
         end
      end

      // Loader and read request in the same IDLE cycle.
      ld_en_a[0] = 1'b1; ld_adr_a[0] = 8'h10; ld_data_a[0] = 8'h33;
      req_a[0] = 1'b1; we_a[0] = 1'b0; adr_a[0] = 8'h10;
      tick();
      ld_en_a[0] = 1'b0;
      check("coll_ld_ack", 32'(ack_a[0]), 32'd1);
      check("coll_not_busy", 32'(busy_a[0]), 32'd0);
      tick();
      check("coll_accepted", 32'(busy_a[0]), 32'd1);
      n = 0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         n++;
         if (ready_a[0]) got = 1'b1;
      end
      req_a[0] = 1'b0;
      check("coll_latency", 32'(n), 32'd2);
      check("coll_memdata", 32'(md_a[0]), 32'h33);
      ref_mem[0][8'h10] = 8'h33; ref_valid[0][8'h10] = 1'b1; ref_md[0] = 8'h33;
      tick();

      // Reset during WAIT drops the pending write and suppresses ready.
      do_load(0, 8'h08, 8'h11);
      req_a[0] = 1'b1; we_a[0] = 1'b1; adr_a[0] = 8'h08; wd_a[0] = 8'h77;
      tick();
      req_a[0] = 1'b0;
      check("mid_busy", 32'(busy_a[0]), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy_a[0]), 32'd0);
      check("mid_rst_ready", 32'(ready_a[0]), 32'd0);
      check("mid_rst_memdata", 32'(md_a[0]), 32'd0);
      tick();
      tick();
      reset = 1'b1;
      ref_md[0] = 8'h00;
      ref_md[1] = 8'h00;
      rcnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (ready_a[0]) rcnt++;
      end
      check("mid_no_ready", 32'(rcnt), 32'd0);
      do_access(0, 1'b0, 8'h08, 8'h00, md);
      check("mid_old_value", 32'(md), 32'h11);

      // Zero wait states.
      do_load(1, 8'hFF, 8'h9C);
      do_access(1, 1'b0, 8'hFF, 8'h00, md);
      check("w0_memdata", 32'(md), 32'h9C);

      // Randomized traffic on both instances.
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 150; i++) begin
            int op;
            logic [7:0] a;
            logic [7:0] d;
            op = int'($urandom_range(0, 2));
            a  = 8'($urandom_range(0, 31));
            d  = 8'($urandom);
            if (op == 0) begin
               do_load(s, a, d);
            end else if (op == 1 || !ref_valid[s][a]) begin
               do_access(s, 1'b1, a, d, md);
            end else begin
               do_access(s, 1'b0, a, 8'h00, md);
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
